// File: rtl/a51_keystream_gen.sv
// A5/1 keystream generator with configurable key, frame, mixing and stream lengths.
// Session sequence: load key bits, load frame bits, majority-clocked mixing with
// output discarded, then stream STREAM_BITS keystream bits in OUT_W-bit beats
// over a valid/ready handshake. The first generated bit of a beat lands in the MSB.
module a51_keystream_gen #(
    parameter int unsigned KEY_BITS    = 64,
    parameter int unsigned FRAME_BITS  = 22,
    parameter int unsigned MIX_CYCLES  = 100,
    parameter int unsigned STREAM_BITS = 228,
    parameter int unsigned OUT_W       = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done
);

    // One shared step counter serves every phase; size it for the longest one.
    localparam int unsigned MAX_KF  = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;
    localparam int unsigned MAX_MS  = (MIX_CYCLES > STREAM_BITS) ? MIX_CYCLES : STREAM_BITS;
    localparam int unsigned CNT_MAX = (MAX_KF > MAX_MS) ? MAX_KF : MAX_MS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BEAT_W  = $clog2(OUT_W + 1);

    localparam logic [CNT_W-1:0]  KEY_LAST   = CNT_W'(KEY_BITS - 1);
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]  MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STREAM_END = CNT_W'(STREAM_BITS);
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(OUT_W - 1);

    if (OUT_W < 1 || OUT_W > STREAM_BITS) begin : g_bad_out_w
        $error("a51_keystream_gen: OUT_W must lie in 1..STREAM_BITS");
    end
    if (OUT_W != 0 && (STREAM_BITS % OUT_W) != 0) begin : g_bad_stream_bits
        $error("a51_keystream_gen: STREAM_BITS must be a multiple of OUT_W");
    end
    if (KEY_BITS < 1 || FRAME_BITS < 1 || MIX_CYCLES < 1) begin : g_bad_lengths
        $error("a51_keystream_gen: KEY_BITS, FRAME_BITS and MIX_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        s_idle,
        s_load_key,
        s_load_frame,
        s_mix,
        s_gen
    } state_t;

    state_t                  state;
    logic [18:0]             r1;
    logic [21:0]             r2;
    logic [22:0]             r3;
    logic [KEY_BITS-1:0]     key_sr;
    logic [FRAME_BITS-1:0]   frame_sr;
    logic [CNT_W-1:0]        cnt;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [OUT_W-1:0]        acc;

    logic                    load_bit;
    logic                    step_all;
    logic                    step_maj;
    logic                    gen_step;
    logic                    maj;
    logic                    en1;
    logic                    en2;
    logic                    en3;
    logic [18:0]             r1_nx;
    logic [21:0]             r2_nx;
    logic [22:0]             r3_nx;
    logic                    ks;
    logic [OUT_W-1:0]        acc_nx;
    logic                    beat_done;
    logic                    accept;
    logic                    last_accept;

    // Decode which kind of register step this cycle performs and the input bit to mix in.
    always_comb begin
        load_bit = 1'b0;
        step_all = 1'b0;
        gen_step = 1'b0;
        case (state)
            s_load_key: begin
                load_bit = key_sr[0];
                step_all = 1'b1;
            end
            s_load_frame: begin
                load_bit = frame_sr[0];
                step_all = 1'b1;
            end
            s_gen: begin
                // Stall while a completed beat is still waiting for the sink.
                gen_step = (cnt != STREAM_END) && !(out_valid && !out_ready);
            end
            default: ;
        endcase
        step_maj = (state == s_mix) || gen_step;
    end

    // Next LFSR contents, majority clocking and the post-step keystream bit.
    always_comb begin
        maj   = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
        en1   = step_all | (step_maj & (r1[8] == maj));
        en2   = step_all | (step_maj & (r2[10] == maj));
        en3   = step_all | (step_maj & (r3[10] == maj));
        r1_nx = en1 ? {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18] ^ load_bit} : r1;
        r2_nx = en2 ? {r2[20:0], r2[20] ^ r2[21] ^ load_bit} : r2;
        r3_nx = en3 ? {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22] ^ load_bit} : r3;
        ks    = r1_nx[18] ^ r2_nx[21] ^ r3_nx[22];
    end

    // Beat assembly and handshake decode.
    always_comb begin
        // Older bits shift toward the MSB, so the first bit of a beat ends up on top.
        acc_nx      = OUT_W'({acc, ks});
        beat_done   = gen_step && (beat_cnt == BEAT_LAST);
        accept      = out_valid && out_ready;
        // Once every bit is generated, the beat on offer is necessarily the last one.
        last_accept = (state == s_gen) && accept && (cnt == STREAM_END);
    end

    // Session FSM, LFSRs, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset || abort) begin
            state     <= s_idle;
            r1        <= '0;
            r2        <= '0;
            r3        <= '0;
            key_sr    <= '0;
            frame_sr  <= '0;
            cnt       <= '0;
            beat_cnt  <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            // Step enables are all low outside the stepping phases, so this holds in idle.
            r1   <= r1_nx;
            r2   <= r2_nx;
            r3   <= r3_nx;
            case (state)
                s_idle: begin
                    if (start) begin
                        key_sr   <= key;
                        frame_sr <= frame;
                        r1       <= '0;
                        r2       <= '0;
                        r3       <= '0;
                        cnt      <= '0;
                        beat_cnt <= '0;
                        acc      <= '0;
                        busy     <= 1'b1;
                        state    <= s_load_key;
                    end
                end
                s_load_key: begin
                    key_sr <= key_sr >> 1;
                    if (cnt == KEY_LAST) begin
                        cnt   <= '0;
                        state <= s_load_frame;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                s_load_frame: begin
                    frame_sr <= frame_sr >> 1;
                    if (cnt == FRAME_LAST) begin
                        cnt   <= '0;
                        state <= s_mix;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                s_mix: begin
                    if (cnt == MIX_LAST) begin
                        cnt   <= '0;
                        state <= s_gen;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                s_gen: begin
                    if (gen_step) begin
                        cnt      <= cnt + 1'b1;
                        acc      <= acc_nx;
                        beat_cnt <= beat_done ? '0 : beat_cnt + 1'b1;
                    end
                    // A beat completing on the accept edge keeps out_valid high with new data.
                    if (beat_done) begin
                        out_data  <= acc_nx;
                        out_valid <= 1'b1;
                    end else if (accept) begin
                        out_valid <= 1'b0;
                    end
                    if (last_accept) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= s_idle;
                    end
                end
                default: state <= s_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_a51_keystream_gen.sv
// Self-checking bench for a51_keystream_gen: one OUT_W=1 and one OUT_W=4 instance share
// the control inputs; streams are compared against a word-level A5/1 reference model.
module tb_a51_keystream_gen;

    localparam int KB = 64;
    localparam int FB = 22;
    localparam int MC = 100;
    localparam int SB = 228;

    localparam logic [63:0] REF_KEY   = 64'hEFCD_AB89_6745_2312;
    localparam logic [21:0] REF_FRAME = 22'h134;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [63:0] key;
    logic [21:0] frame;
    logic        out_ready;
    logic        out_ready4;
    logic [0:0]  out_data1;
    logic        out_valid1;
    logic        busy1;
    logic        done1;
    logic [3:0]  out_data4;
    logic        out_valid4;
    logic        busy4;
    logic        done4;

    int nvec = 0;
    int nerr = 0;

    bit       ref_bits[SB];
    bit       got_bits[SB];
    int       got_n;
    logic [3:0] beats4[SB/4];

    a51_keystream_gen #(
        .KEY_BITS(KB), .FRAME_BITS(FB), .MIX_CYCLES(MC), .STREAM_BITS(SB), .OUT_W(1)
    ) u_dut1 (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .key(key),
        .frame(frame), .out_ready(out_ready), .out_data(out_data1),
        .out_valid(out_valid1), .busy(busy1), .done(done1)
    );

    a51_keystream_gen #(
        .KEY_BITS(KB), .FRAME_BITS(FB), .MIX_CYCLES(MC), .STREAM_BITS(SB), .OUT_W(4)
    ) u_dut4 (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .key(key),
        .frame(frame), .out_ready(out_ready4), .out_data(out_data4),
        .out_valid(out_valid4), .busy(busy4), .done(done4)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int unsigned adv(input int unsigned v, input int unsigned n,
                                        input int unsigned m, input bit in);
        bit fb;
        fb = (^(v & m)) ^ in;
        return ((v << 1) | 32'(fb)) & ((32'd1 << n) - 32'd1);
    endfunction

    // Word-level A5/1: registers held as integers, feedback as parity of a tap mask.
    task automatic build_ref(input logic [63:0] k, input logic [21:0] f);
        int unsigned len[3];
        int unsigned mask[3];
        int unsigned ckb[3];
        int unsigned r[3];
        int ones;
        bit maj;
        bit in;
        bit x;
        len  = '{19, 22, 23};
        mask = '{32'h0007_2000, 32'h0030_0000, 32'h0070_0080};
        ckb  = '{8, 10, 10};
        r    = '{0, 0, 0};
        for (int i = 0; i < KB + FB; i++) begin
            in = (i < KB) ? k[i] : f[i-KB];
            for (int j = 0; j < 3; j++) r[j] = adv(r[j], len[j], mask[j], in);
        end
        for (int t = 0; t < MC + SB; t++) begin
            ones = 0;
            for (int j = 0; j < 3; j++) ones += int'((r[j] >> ckb[j]) & 1);
            maj = (ones >= 2);
            for (int j = 0; j < 3; j++)
                if (((r[j] >> ckb[j]) & 1) == 32'(maj)) r[j] = adv(r[j], len[j], mask[j], 1'b0);
            if (t >= MC) begin
                x = 1'b0;
                for (int j = 0; j < 3; j++) x ^= bit'((r[j] >> (len[j] - 1)) & 1);
                ref_bits[t-MC] = x;
            end
        end
    endtask

    // Runs one OUT_W=1 session with random stalls; optionally pulses start mid-session.
    task automatic run_session(input logic [63:0] k, input logic [21:0] f, input int low_pct,
                               input int glitch_at);
        bit         stall;
        logic [0:0] held;
        bit         fin;
        build_ref(k, f);
        key = k; frame = f; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_after_start", busy1, 1);
        got_n = 0;
        fin   = 0;
        for (int cyc = 1; cyc < 4000 && !fin; cyc++) begin
            if (cyc == glitch_at) begin start = 1'b1; key = ~k; end
            else begin start = 1'b0; key = k; end
            out_ready = ($urandom_range(0, 99) >= low_pct);
            if (out_valid1 && out_ready && got_n < SB) begin
                got_bits[got_n] = out_data1[0];
                got_n++;
            end
            stall = out_valid1 && !out_ready;
            held  = out_data1;
            tick();
            if (stall) begin
                check_eq("stall_valid", out_valid1, 1);
                check_eq("stall_data", out_data1, held);
            end
            if (got_n == SB) begin
                check_eq("done_on_last", done1, 1);
                check_eq("busy_on_last", busy1, 0);
                check_eq("valid_on_last", out_valid1, 0);
                fin = 1;
            end else begin
                check_eq("no_early_done", done1, 0);
            end
        end
        start = 1'b0; key = k; out_ready = 1'b1;
        check_eq("stream_len", got_n, SB);
        for (int i = 0; i < got_n; i++)
            check_eq($sformatf("bit%0d", i), got_bits[i], ref_bits[i]);
        tick();
        check_eq("done_one_cycle", done1, 0);
    endtask

    initial begin
        int          lat;
        int          n1;
        int          n4;
        int          first4;
        int          last4;
        bit          fin1;
        bit          fin4;
        bit          orall;
        logic [31:0] w;
        logic [3:0]  nib;

        reset = 1'b1; start = 1'b0; abort = 1'b0; key = '0; frame = '0;
        out_ready = 1'b1; out_ready4 = 1'b1;
        repeat (3) tick();
        check_eq("rst_valid1", out_valid1, 0);
        check_eq("rst_busy1", busy1, 0);
        check_eq("rst_done1", done1, 0);
        check_eq("rst_data1", out_data1, 0);
        check_eq("rst_valid4", out_valid4, 0);
        check_eq("rst_data4", out_data4, 0);
        reset = 1'b0;
        tick();

        // Reference vector, both widths, sink always ready.
        build_ref(REF_KEY, REF_FRAME);
        key = REF_KEY; frame = REF_FRAME; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("ref_busy1", busy1, 1);
        check_eq("ref_busy4", busy4, 1);
        lat = 0;
        while (!out_valid1 && lat < 400) begin
            tick();
            lat++;
        end
        check_eq("first_valid_lat", lat, 187);
        n1 = 0; n4 = 0; first4 = -1; last4 = 0; fin1 = 0; fin4 = 0;
        for (int cyc = 0; cyc < 600 && !(fin1 && fin4); cyc++) begin
            if (out_valid1 && n1 < SB) begin
                got_bits[n1] = out_data1[0];
                n1++;
            end
            if (out_valid4 && n4 < SB / 4) begin
                if (n4 == 0) first4 = cyc;
                else check_eq("w4_beat_gap", cyc - last4, 4);
                last4     = cyc;
                beats4[n4] = out_data4;
                n4++;
            end
            tick();
            if (n1 == SB && !fin1) begin
                check_eq("w1_done", done1, 1);
                check_eq("w1_busy_fall", busy1, 0);
                check_eq("w1_valid_end", out_valid1, 0);
                fin1 = 1;
            end
            if (n4 == SB / 4 && !fin4) begin
                check_eq("w4_done", done4, 1);
                check_eq("w4_busy_fall", busy4, 0);
                fin4 = 1;
            end
        end
        check_eq("w1_bits", n1, SB);
        check_eq("w4_beats", n4, 57);
        check_eq("w4_first_lat", 187 + first4, 190);
        tick();
        check_eq("w1_done_pulse", done1, 0);
        check_eq("w4_done_pulse", done4, 0);
        w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], got_bits[i]};
        check_eq("ref_bits_0_31", w, 32'h534E_AA58);
        w = '0;
        for (int i = 114; i < 146; i++) w = {w[30:0], got_bits[i]};
        check_eq("ref_bits_114_145", w, 32'h24FD_35A3);
        for (int i = 0; i < SB; i++) check_eq($sformatf("ref_bit%0d", i), got_bits[i], ref_bits[i]);
        check_eq("w4_beat0", beats4[0], 4'h5);
        check_eq("w4_beat1", beats4[1], 4'h3);
        check_eq("w4_beat2", beats4[2], 4'h4);
        check_eq("w4_beat3", beats4[3], 4'hE);
        for (int b = 0; b < SB / 4; b++) begin
            nib = {ref_bits[4*b], ref_bits[4*b+1], ref_bits[4*b+2], ref_bits[4*b+3]};
            check_eq($sformatf("w4_beat%0d_model", b), beats4[b], nib);
        end

        // Backpressure on the reference vector and on random vectors.
        run_session(REF_KEY, REF_FRAME, 30, 0);
        for (int s = 0; s < 2; s++)
            run_session({$urandom, $urandom}, 22'($urandom), 30, 0);

        // All-zero key and frame keeps every register at zero.
        run_session('0, '0, 0, 0);
        orall = 0;
        for (int i = 0; i < got_n; i++) orall |= got_bits[i];
        check_eq("zero_stream", orall, 0);

        // Start pulsed (with a different key) during mixing must be ignored.
        run_session(REF_KEY, REF_FRAME, 10, 95);

        // Abort mid-stream.
        key = REF_KEY; frame = REF_FRAME; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 400) begin
            tick();
            lat++;
        end
        check_eq("abort_reach_gen", out_valid1, 1);
        repeat (40) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_valid", out_valid1, 0);
        check_eq("abort_busy", busy1, 0);
        check_eq("abort_done", done1, 0);
        check_eq("abort_data", out_data1, 0);
        check_eq("abort_busy4", busy4, 0);
        repeat (3) tick();
        check_eq("abort_no_done", done1, 0);
        check_eq("abort_stay_idle", busy1, 0);
        run_session(REF_KEY, REF_FRAME, 0, 0);

        // Synchronous reset during frame loading, then reset held with start high.
        key = REF_KEY; frame = REF_FRAME; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (70) tick();
        check_eq("pre_reset_busy", busy1, 1);
        reset = 1'b1;
        tick();
        check_eq("rst_mid_valid", out_valid1, 0);
        check_eq("rst_mid_busy", busy1, 0);
        check_eq("rst_mid_done", done1, 0);
        check_eq("rst_mid_data", out_data1, 0);
        check_eq("rst_mid_busy4", busy4, 0);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_hold_busy", busy1, 0);
        end
        reset = 1'b0; start = 1'b0;
        tick();
        check_eq("rst_no_session", busy1, 0);
        run_session(REF_KEY, REF_FRAME, 0, 0);
        w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], got_bits[i]};
        check_eq("post_reset_ref", w, 32'h534E_AA58);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/a51_keystream_gen.md
Name: a51_keystream_gen

Overview:
- Parametrised A5/1 keystream generator; successor to the fixed single-bit A5/1 core used by the LCD/PS2 encrypt-decrypt top.
- Loads key and frame number, runs the mixing phase, then streams STREAM_BITS of keystream in OUT_W-bit beats over a valid/ready handshake.
- Adds backpressure, abort, busy/done status and configurable key, frame, mixing and stream lengths.
- Sits between the key-entry controller and the XOR data path.

Parameters:
- KEY_BITS, 64, session key length; one load step per bit.
- FRAME_BITS, 22, frame number length; one load step per bit.
- MIX_CYCLES, 100, majority-clocked steps with output discarded.
- STREAM_BITS, 228, keystream bits per session; STREAM_BITS % OUT_W must be 0, else elaboration error.
- OUT_W, 1, keystream bits per output beat (1..STREAM_BITS).

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin session; sampled only in IDLE.
- abort  in  1  return to IDLE next edge; overrides everything except reset.
- key  in  KEY_BITS  session key; captured on accepted start.
- frame  in  FRAME_BITS  frame number; captured on accepted start.
- out_ready  in  1  sink ready.
- out_data  out  OUT_W  keystream beat; first-generated bit in [OUT_W-1].
- out_valid  out  1  out_data valid.
- busy  out  1  high from the edge that accepts start until IDLE.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Registers:
  - R1 is 19 bits, taps 13,16,17,18, clock bit 8.
  - R2 is 22 bits, taps 20,21, clock bit 10.
  - R3 is 23 bits, taps 7,20,21,22, clock bit 10.
  - A step shifts toward the MSB; bit 0 takes the XOR of the taps (load phases also XOR in the input bit).
  - Keystream bit = R1[18]^R2[21]^R3[22], taken after the step.
- Reset or abort: FSM to IDLE; R1/R2/R3, bit counter, beat accumulator and out_data all 0; out_valid=0, busy=0, done=0.
- IDLE: start=1 captures key/frame, clears R1-R3, sets busy=1 and moves to LOAD_KEY. start while busy is ignored.
- LOAD_KEY: KEY_BITS cycles, one per edge, key bit i (i=0 first). All three registers step every cycle, with the key bit XORed into each feedback.
- LOAD_FRAME: FRAME_BITS cycles, frame bit i (i=0 first), same regular clocking.
- MIX: MIX_CYCLES majority-clocked steps.
  - maj = majority of the three clock bits.
  - A register steps iff its clock bit equals maj.
  - Output is discarded.
- GEN:
  - A majority step occurs each cycle unless out_valid && !out_ready.
  - Each step shifts one keystream bit into the accumulator.
  - On the step completing OUT_W bits: out_data gets the accumulator contents and out_valid=1 on the same edge.
  - The accept edge (out_valid && out_ready) clears out_valid unless a new beat completes on that same edge, in which case out_valid stays 1 with new data.
  - With out_ready held high: one beat every OUT_W cycles.
- First out_valid is high after KEY_BITS+FRAME_BITS+MIX_CYCLES+OUT_W edges following the start-accept edge. With defaults and OUT_W=1 that is 187.
- The last beat (STREAM_BITS/OUT_W-th) is accepted. On that edge: out_valid=0, done=1 for one cycle, busy=0, return to IDLE. A start on the cycle done is high is accepted.
- out_data holds its value while out_valid && !out_ready; it is don't-care when out_valid=0.
- Counters are sized with $clog2 of their max value plus 1; no wrap occurs within a session.

Test Plan:
- Reference vector, OUT_W=1:
  - Stimulus: key=64'hEFCDAB8967452312 (byte0=0x12 in key[7:0]), frame=22'h134, out_ready=1.
  - Response: first out_valid 187 edges after start; stream bits 0..31 = 0x534EAA58 (MSB first); bits 114..145 = 0x24FD35A3; done pulses after bit 227; busy falls on the same edge.
- Same vector, OUT_W=4:
  - Response: first beats 4'h5, 4'h3, 4'h4, 4'hE; 57 beats total; one beat per 4 cycles.
- Backpressure, OUT_W=1:
  - Stimulus: random out_ready, 30% low.
  - Response: accepted bit sequence identical to the unthrottled run; out_data stable while stalled; no beat lost or duplicated.
- Zero key and zero frame:
  - Response: all 228 keystream bits 0 (registers remain 0).
- Control corner cases:
  - Start pulsed during MIX: ignored, stream unchanged.
  - Abort asserted mid-GEN: next edge out_valid=0, busy=0, no done.
  - Restart: the fresh stream matches the first run.
- Synchronous reset asserted in LOAD_FRAME:
  - Response: next edge all outputs 0, FSM in IDLE.
  - Reset held while start=1: no session starts.
  - A subsequent normal run reproduces the reference vector.
